// File: rtl/clock_div_prog.sv
// Runtime-programmable glitch-free clock divider with period tick.
// Optional CLKDIV_SYNC_EN adds a sync_in port that re-phases the output while running.
module clock_div_prog #(
  parameter int unsigned MAX_DIV    = 256,
  parameter int unsigned DEF_PERIOD = 4,
  parameter int unsigned DEF_HIGH   = 2,
  localparam int unsigned CW        = $clog2(MAX_DIV + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync_in,
`endif
  output logic          new_clock,
  output logic          period_tick,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, next_cnt;
  logic [CW-1:0] period_q, period_d, high_q, high_d;
  logic [CW-1:0] pend_period, pend_period_d, pend_high, pend_high_d;
  logic [CW-1:0] san_period, san_high;
  logic          pending, pending_d;
  logic          clk_d, tick_d;
  logic          accept, wrap, sync_hit, apply_edge;

  // Clamp an offered word into a legal period/high pair
  always_comb begin
    san_period = cfg_period;
    if (cfg_period < CW'(2))            san_period = CW'(2);
    else if (cfg_period > CW'(MAX_DIV)) san_period = CW'(MAX_DIV);
    san_high = cfg_high;
    if (cfg_high == '0)                 san_high = CW'(1);
    else if (cfg_high >= san_period)    san_high = san_period - CW'(1);
  end

  // Next-state, config staging and output decode
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    period_d      = period_q;
    high_d        = high_q;
    pend_period_d = pend_period;
    pend_high_d   = pend_high;
    pending_d     = pending;
    clk_d         = 1'b0;
    tick_d        = 1'b0;

    accept   = cfg_valid && cfg_ready;
    wrap     = (cnt == period_q - CW'(1));
    next_cnt = cnt + CW'(1);
`ifdef CLKDIV_SYNC_EN
    sync_hit = (state == RUN) && sync_in;
`else
    sync_hit = 1'b0;
`endif
    apply_edge = (state == IDLE) || wrap || sync_hit;

    if (accept) begin
      pend_period_d = san_period;
      pend_high_d   = san_high;
      pending_d     = 1'b1;
    end
    // A word accepted on a boundary edge bypasses the pending buffer
    if (apply_edge && accept) begin
      period_d  = san_period;
      high_d    = san_high;
      pending_d = 1'b0;
    end else if (apply_edge && pending) begin
      period_d  = pend_period;
      high_d    = pend_high;
      pending_d = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap || sync_hit) begin
          cnt_d = '0;
          if (state == RUN || enable) begin
            clk_d   = 1'b1;
            tick_d  = 1'b1;
            state_d = enable ? RUN : STOPPING;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = next_cnt;
          clk_d   = (next_cnt < high_q);
          state_d = enable ? RUN : STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      period_q    <= CW'(DEF_PERIOD);
      high_q      <= CW'(DEF_HIGH);
      pend_period <= CW'(DEF_PERIOD);
      pend_high   <= CW'(DEF_HIGH);
      pending     <= 1'b0;
      cfg_ready   <= 1'b1;
      new_clock   <= 1'b0;
      period_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      pend_period <= pend_period_d;
      pend_high   <= pend_high_d;
      pending     <= pending_d;
      cfg_ready   <= !pending_d;
      new_clock   <= clk_d;
      period_tick <= tick_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed scenarios plus random traffic against a
// period-queue reference model of the divided-clock waveform.
module tb_clock_div_prog;
  localparam int unsigned CW = 9;

  logic          clock = 1'b0;
  logic          reset, enable, cfg_valid, sync_in;
  logic [CW-1:0] cfg_period, cfg_high;
  logic          cfg_ready, new_clock, period_tick, busy;

  always #5 clock = ~clock;

  clock_div_prog dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
`ifdef CLKDIV_SYNC_EN
    .sync_in     (sync_in),
`endif
    .new_clock   (new_clock),
    .period_tick (period_tick),
    .busy        (busy)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: each period is a queue of output levels
  bit m_active, m_run, m_pend;
  int cur_p, cur_h, pend_p, pend_h;
  bit wave[$];
  bit e_clk, e_tick, e_busy, e_ready;

  function automatic void sanitize(input int p, input int h, output int sp, output int sh);
    sp = (p < 2) ? 2 : ((p > 256) ? 256 : p);
    sh = (h == 0) ? 1 : ((h >= sp) ? sp - 1 : h);
  endfunction

  function automatic void start_period();
    wave.delete();
    for (int i = 0; i < cur_p; i++) wave.push_back(i < cur_h);
    e_clk  = wave.pop_front();
    e_tick = 1'b1;
  endfunction

  function automatic void model_edge();
    bit acc, boundary, sy;
    int sp, sh;
    sy = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sy = sync_in;
`endif
    if (reset) begin
      m_active = 0; m_run = 0; m_pend = 0;
      cur_p = 4; cur_h = 2;
      wave.delete();
      e_clk = 0; e_tick = 0; e_busy = 0; e_ready = 1;
      return;
    end
    acc = cfg_valid && !m_pend;
    sanitize(int'(cfg_period), int'(cfg_high), sp, sh);
    if (!m_active) begin
      if (acc) begin cur_p = sp; cur_h = sh; end
      if (enable) begin
        m_active = 1; m_run = 1;
        start_period();
      end else begin
        e_clk = 0; e_tick = 0;
      end
    end else begin
      boundary = (wave.size() == 0) || (sy && m_run);
      if (boundary && acc) begin
        cur_p = sp; cur_h = sh;
      end else if (boundary && m_pend) begin
        cur_p = pend_p; cur_h = pend_h; m_pend = 0;
      end else if (acc) begin
        pend_p = sp; pend_h = sh; m_pend = 1;
      end
      if (boundary) begin
        if (m_run || enable) begin
          start_period();
          m_run = enable;
        end else begin
          m_active = 0; m_run = 0;
          e_clk = 0; e_tick = 0;
        end
      end else begin
        e_clk  = wave.pop_front();
        e_tick = 1'b0;
        m_run  = enable;
      end
    end
    e_busy  = m_active;
    e_ready = !m_pend;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    chk({tag, ".new_clock"},   new_clock,   e_clk);
    chk({tag, ".period_tick"}, period_tick, e_tick);
    chk({tag, ".busy"},        busy,        e_busy);
    chk({tag, ".cfg_ready"},   cfg_ready,   e_ready);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic offer(input int p, input int h, input string tag);
    cfg_valid = 1'b1; cfg_period = CW'(p); cfg_high = CW'(h);
    step(tag);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step(tag);
      seen = period_tick;
    end
    chk({tag, ".tick_seen"}, seen, 1'b1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; sync_in = 1'b0;
    cfg_period = '0; cfg_high = '0;
    run(2, "reset");
    reset = 1'b0;
    run(2, "idle");

    // Defaults give 1100 with a tick every fourth cycle
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step("t1");
      chk("t1.pattern", new_clock, (i % 4) < 2);
      chk("t1.tick",    period_tick, (i % 4) == 0);
    end

    // Mid-period reconfigure waits for the wrap
    step("t2");
    offer(5, 2, "t2.offer");
    chk("t2.ready_low", cfg_ready, 1'b0);
    run(12, "t2");

    // Clamping of illegal words
    offer(1, 0, "t3a.offer");
    run(10, "t3a");
    offer(3, 7, "t3b.offer");
    run(10, "t3b");

    // Stop mid-period, then stop-and-resume without a gap
    offer(4, 2, "t4.offer");
    wait_tick("t4.align");
    step("t4.cnt1");
    enable = 1'b0;
    run(3, "t4.stop");
    chk("t4.busy_fell", busy, 1'b0);
    run(3, "t4.idle");
    enable = 1'b1;
    wait_tick("t4.restart");
    step("t4.cnt1b");
    enable = 1'b0;
    step("t4.cnt2");
    enable = 1'b1;
    run(8, "t4.resume");

    // Reset during a high phase restores defaults
    offer(8, 4, "t5.offer");
    wait_tick("t5.align");
    wait_tick("t5.align2");
    step("t5.high");
    reset = 1'b1;
    step("t5.reset");
    chk("t5.clk_dropped", new_clock, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step("t5.defaults");
      chk("t5.pattern", new_clock, (i % 4) < 2);
    end

`ifdef CLKDIV_SYNC_EN
    offer(6, 3, "t6.offer");
    wait_tick("t6.align");
    wait_tick("t6.align2");
    run(4, "t6.cnt4");
    sync_in = 1'b1;
    step("t6.sync");
    sync_in = 1'b0;
    chk("t6.sync_tick", period_tick, 1'b1);
    chk("t6.sync_clk",  new_clock,   1'b1);
    for (int i = 1; i < 6; i++) begin
      step("t6.after");
      chk("t6.pattern", new_clock, i < 3);
    end
`endif

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_period = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 511))
                                                : CW'($urandom_range(0, 12));
      cfg_high  = CW'($urandom_range(0, 14));
`ifdef CLKDIV_SYNC_EN
      sync_in   = ($urandom_range(0, 19) == 0);
`endif
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
